// File: rtl/sample_averager.sv
// Accumulates n_avg unsigned samples, launches an external divider with sum/count and
// publishes the quotient. Define AVG_ROUND_EN to add n_eff/2 to the dividend (round-half-up).
module sample_averager #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 17,
  parameter int unsigned N     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [CNT_W-1:0] n_avg,
  input  logic             sample_valid,
  input  logic [DW-1:0]    sample,
  output logic             div_start,
  output logic [N-1:0]     div_divident,
  output logic [N-1:0]     div_divider,
  input  logic             div_ready,
  input  logic [N-1:0]     div_quotient,
  output logic [N-1:0]     avg_out,
  output logic             avg_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {StIdle, StAccum, StLaunch, StWait} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_eff_q, n_eff_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  logic [N-1:0]     sum_q, sum_d;
  logic [N-1:0]     avg_q, avg_d;
  logic             avg_valid_q, avg_valid_d;
  logic             overrun_q, overrun_d;

  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    n_eff_d     = n_eff_q;
    count_d     = count_q;
    sum_d       = sum_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    overrun_d   = overrun_q;
    // arm wins in every state, including over a same-cycle sample or divider result
    if (arm) begin
      state_d   = StAccum;
      n_eff_d   = (n_avg == '0) ? CNT_W'(1) : n_avg;
      count_d   = '0;
      sum_d     = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAccum: begin
          if (sample_valid) begin
            sum_d   = sum_q + N'(sample);
            count_d = count_inc;
            if (count_inc == n_eff_q) state_d = StLaunch;
          end
        end
        StLaunch: begin
          if (sample_valid) overrun_d = 1'b1;
          state_d = StWait;
        end
        StWait: begin
          if (sample_valid) overrun_d = 1'b1;
          if (div_ready) begin
            avg_d       = div_quotient;
            avg_valid_d = 1'b1;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      n_eff_q     <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_eff_q     <= n_eff_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign div_start   = (state_q == StLaunch);
  assign div_divider = N'(n_eff_q);
`ifdef AVG_ROUND_EN
  assign div_divident = sum_q + N'(n_eff_q >> 1);
`else
  assign div_divident = sum_q;
`endif
  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_averager.sv
// Directed bench for sample_averager with a 64-iteration divider model.
// Build with +define+AVG_ROUND_EN to check the rounding variant.
module tb_sample_averager;

  localparam int unsigned DW = 16;
  localparam int unsigned CNT_W = 17;
  localparam int unsigned N = 64;
`ifdef AVG_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             arm = 1'b0;
  logic [CNT_W-1:0] n_avg = '0;
  logic             sample_valid = 1'b0;
  logic [DW-1:0]    sample = '0;
  logic             div_start;
  logic [N-1:0]     div_divident;
  logic [N-1:0]     div_divider;
  logic             div_ready;
  logic [N-1:0]     div_quotient = '0;
  logic [N-1:0]     avg_out;
  logic             avg_valid;
  logic             busy;
  logic             overrun;

  int n_checks = 0;
  int n_pass = 0;
  int div_cnt = 0;

  always #5 clk = ~clk;

  sample_averager #(.DW(DW), .CNT_W(CNT_W), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .n_avg        (n_avg),
    .sample_valid (sample_valid),
    .sample       (sample),
    .div_start    (div_start),
    .div_divident (div_divident),
    .div_divider  (div_divider),
    .div_ready    (div_ready),
    .div_quotient (div_quotient),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Divider model: drops ready on the start edge, ready again 64 edges later.
  assign div_ready = (div_cnt == 0);
  always @(posedge clk) begin
    if (div_start) begin
      div_cnt      <= 64;
      div_quotient <= (div_divider != 0) ? div_divident / div_divider : '0;
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [CNT_W-1:0] n);
    arm = 1'b1;
    n_avg = n;
    step();
    arm = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] v);
    sample_valid = 1'b1;
    sample = v;
    step();
    sample_valid = 1'b0;
  endtask

  // Returns edges until avg_valid (-1 on timeout) and extra div_start cycles seen.
  task automatic wait_valid(output int edges, output int starts);
    edges = -1;
    starts = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (div_start) starts++;
      if (avg_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({avg_out, avg_valid, busy, overrun, div_start} !== '0)
      $display("FAIL reset_outs: avg_out=%0d valid=%b busy=%b ovr=%b start=%b, required 0",
               avg_out, avg_valid, busy, overrun, div_start);
    else n_pass++;
    n_checks++;
    if (div_divident !== '0 || div_divider !== '0)
      $display("FAIL reset_div: divident=%0d divider=%0d, required 0", div_divident, div_divider);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int edges, starts;
    do_arm(4);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b, required 1", busy);
    else n_pass++;
    feed(10); feed(20); feed(30);
    n_checks++;
    if (div_start !== 1'b0) $display("FAIL basic_early_start: got %b, required 0", div_start);
    else n_pass++;
    feed(40);
    n_checks++;
    if (div_start !== 1'b1 || div_divident !== 64'(100 + (Rnd ? 2 : 0)) || div_divider !== 64'd4)
      $display("FAIL basic_launch: start=%b divident=%0d divider=%0d, required 1/%0d/4",
               div_start, div_divident, div_divider, 100 + (Rnd ? 2 : 0));
    else n_pass++;
    wait_valid(edges, starts);
    n_checks++;
    if (edges != 66 || starts != 0)
      $display("FAIL basic_latency: edges=%0d extra_starts=%0d, required 66/0", edges, starts);
    else n_pass++;
    n_checks++;
    if (avg_out !== 64'd25) $display("FAIL basic_avg: got %0d, required 25", avg_out);
    else n_pass++;
    step();
    n_checks++;
    if (avg_valid !== 1'b0 || busy !== 1'b0 || avg_out !== 64'd25)
      $display("FAIL basic_after: valid=%b busy=%b avg=%0d, required 0/0/25",
               avg_valid, busy, avg_out);
    else n_pass++;
  endtask

  task automatic test_round();
    int edges, starts;
    logic [N-1:0] exp_q;
    exp_q = Rnd ? 64'd2 : 64'd1;
    do_arm(4);
    feed(1); feed(2); feed(2); feed(2);
    wait_valid(edges, starts);
    n_checks++;
    if (edges != 66 || avg_out !== exp_q)
      $display("FAIL round_avg: edges=%0d avg=%0d, required 66/%0d", edges, avg_out, exp_q);
    else n_pass++;
  endtask

  task automatic test_zero_navg();
    int edges, starts;
    do_arm(0);
    feed(123);
    n_checks++;
    if (div_start !== 1'b1 || div_divider !== 64'd1 || div_divident !== 64'd123)
      $display("FAIL zero_launch: start=%b divider=%0d divident=%0d, required 1/1/123",
               div_start, div_divider, div_divident);
    else n_pass++;
    wait_valid(edges, starts);
    n_checks++;
    if (edges != 66 || avg_out !== 64'd123)
      $display("FAIL zero_avg: edges=%0d avg=%0d, required 66/123", edges, avg_out);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int edges, starts;
    do_arm(2);
    feed(8); feed(8);
    step();
    step();
    feed(77);
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b, required 1", overrun);
    else n_pass++;
    wait_valid(edges, starts);
    n_checks++;
    if (avg_out !== 64'd8 || overrun !== 1'b1)
      $display("FAIL overrun_avg: avg=%0d ovr=%b, required 8/1", avg_out, overrun);
    else n_pass++;
    step();
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b, required 1", overrun);
    else n_pass++;
    do_arm(1);
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b, required 0", overrun);
    else n_pass++;
  endtask

  task automatic test_rearm();
    int edges, starts;
    do_arm(4);
    feed(99); feed(99);
    // re-arm with a concurrent sample that must not be counted
    sample_valid = 1'b1;
    sample = 16'd1000;
    do_arm(4);
    sample_valid = 1'b0;
    feed(5); feed(5); feed(5);
    n_checks++;
    if (div_start !== 1'b0) $display("FAIL rearm_early: start=%b, required 0", div_start);
    else n_pass++;
    feed(5);
    n_checks++;
    if (div_start !== 1'b1 || div_divident !== 64'(20 + (Rnd ? 2 : 0)))
      $display("FAIL rearm_launch: start=%b divident=%0d, required 1/%0d",
               div_start, div_divident, 20 + (Rnd ? 2 : 0));
    else n_pass++;
    wait_valid(edges, starts);
    n_checks++;
    if (edges != 66 || avg_out !== 64'd5)
      $display("FAIL rearm_avg: edges=%0d avg=%0d, required 66/5", edges, avg_out);
    else n_pass++;
  endtask

  task automatic test_reset_wait();
    int pulses;
    do_arm(1);
    feed(7);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || avg_out !== '0)
      $display("FAIL rstwait_state: busy=%b avg=%0d, required 0/0", busy, avg_out);
    else n_pass++;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (avg_valid || div_start) pulses++;
    end
    n_checks++;
    if (pulses != 0 || avg_out !== '0)
      $display("FAIL rstwait_quiet: pulses=%0d avg=%0d, required 0/0", pulses, avg_out);
    else n_pass++;
  endtask

  task automatic test_idle_ignore();
    feed(500); feed(600);
    n_checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || div_start !== 1'b0)
      $display("FAIL idle_ignore: busy=%b ovr=%b start=%b, required 0/0/0",
               busy, overrun, div_start);
    else n_pass++;
  endtask

  // 65540 full-scale samples push the sum past 32 bits.
  task automatic test_big();
    int edges, starts;
    logic [N-1:0] exp_div;
    exp_div = 64'd4295163900 + (Rnd ? 64'd32770 : 64'd0);
    do_arm(17'd65540);
    sample_valid = 1'b1;
    sample = 16'hFFFF;
    repeat (65540) step();
    sample_valid = 1'b0;
    n_checks++;
    if (div_start !== 1'b1 || div_divident !== exp_div || div_divider !== 64'd65540)
      $display("FAIL big_launch: start=%b divident=%0d divider=%0d, required 1/%0d/65540",
               div_start, div_divident, div_divider, exp_div);
    else n_pass++;
    wait_valid(edges, starts);
    n_checks++;
    if (edges != 66 || avg_out !== 64'd65535 || overrun !== 1'b0)
      $display("FAIL big_avg: edges=%0d avg=%0d ovr=%b, required 66/65535/0",
               edges, avg_out, overrun);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_zero_navg();
    test_overrun();
    test_rearm();
    test_reset_wait();
    test_idle_ignore();
    test_big();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
